// File: rtl/ones_cnt_datapath.sv
// Ones-counter datapath: R1 shift register, R2 ones counter, E carry-out flop,
// plus a result register captured on each rising edge of the controller's rdy.
module ones_cnt_datapath #(
    parameter int WIDTH = 8,
    parameter int CNT_W = $clog2(WIDTH + 1)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] data_in,
    input  logic             load_regs,
    input  logic             incr_r2,
    input  logic             shift,
    input  logic             rdy,
    output logic             zero,
    output logic             E,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] result,
    output logic             result_valid,
    output logic             cmd_err
);

    logic [WIDTH-1:0] r1;
    logic [CNT_W-1:0] r2;
    logic             e_q;
    logic             rdy_q;
    logic             multi_cmd;

    assign multi_cmd = (load_regs & incr_r2) | (load_regs & shift) | (incr_r2 & shift);

    // R2 is preset to all-ones on load so the controller's first incr lands on zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r1  <= '0;
            r2  <= '0;
            e_q <= 1'b0;
        end else if (load_regs) begin
            r1  <= data_in;
            r2  <= '1;
            e_q <= 1'b0;
        end else if (incr_r2) begin
            r2 <= r2 + CNT_W'(1);
        end else if (shift) begin
            e_q <= r1[WIDTH-1];
            r1  <= {r1[WIDTH-2:0], 1'b0};
        end
    end

    // rdy_q resets high so leaving reset with rdy=1 does not look like a rising edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rdy_q        <= 1'b1;
            result       <= '0;
            result_valid <= 1'b0;
        end else begin
            rdy_q        <= rdy;
            result_valid <= rdy & ~rdy_q;
            if (rdy && !rdy_q) begin
                result <= r2;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cmd_err <= 1'b0;
        end else if (multi_cmd) begin
            cmd_err <= 1'b1;
        end
    end

    assign zero  = (r1 == '0);
    assign E     = e_q;
    assign count = r2;

endmodule

// File: tb/tb_ones_cnt_datapath.sv
// Scoreboard bench for ones_cnt_datapath: the initial block plays the controller
// and queues expected results; a monitor pops them on every result_valid pulse.
module tb_ones_cnt_datapath;

    localparam int WIDTH = 8;
    localparam int CNT_W = 4;

    logic             clk;
    logic             rst;
    logic [WIDTH-1:0] data_in;
    logic             load_regs;
    logic             incr_r2;
    logic             shift;
    logic             rdy;
    logic             zero;
    logic             E;
    logic [CNT_W-1:0] count;
    logic [CNT_W-1:0] result;
    logic             result_valid;
    logic             cmd_err;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    logic [CNT_W-1:0] exp_q[$];

    logic [WIDTH-1:0] m_r1;
    logic [CNT_W-1:0] m_r2;
    logic             m_e;
    logic             prev_valid;

    ones_cnt_datapath #(.WIDTH(WIDTH)) dut (
        .clk(clk),
        .rst(rst),
        .data_in(data_in),
        .load_regs(load_regs),
        .incr_r2(incr_r2),
        .shift(shift),
        .rdy(rdy),
        .zero(zero),
        .E(E),
        .count(count),
        .result(result),
        .result_valid(result_valid),
        .cmd_err(cmd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every result_valid pulse must match the oldest queued expectation.
    always @(negedge clk) begin
        if (!rst) begin
            if (result_valid) begin
                pulses++;
                if (exp_q.size() == 0) begin
                    checkOutput("unexpected_result_valid", 32'(result), 32'hFFFF_FFFF);
                end else begin
                    checkOutput("result", 32'(result), 32'(exp_q.pop_front()));
                end
                if (prev_valid) checkOutput("result_valid_width", 32'd2, 32'd1);
            end
            prev_valid <= result_valid;
        end else begin
            prev_valid <= 1'b0;
        end
    end

    // One clock with the given commands; the local model tracks the expected datapath state.
    task automatic applyStimulus(input logic ld, input logic inc, input logic sh, input logic rd);
        load_regs = ld;
        incr_r2   = inc;
        shift     = sh;
        rdy       = rd;
        @(posedge clk);
        #1;
        if (ld) begin
            m_r1 = data_in;
            m_r2 = '1;
            m_e  = 1'b0;
        end else if (inc) begin
            m_r2 = m_r2 + 4'd1;
        end else if (sh) begin
            m_e  = m_r1[WIDTH-1];
            m_r1 = m_r1 << 1;
        end
        checkOutput("count", 32'(count), 32'(m_r2));
        checkOutput("E", 32'(E), 32'(m_e));
        checkOutput("zero", 32'(zero), 32'(m_r1 == '0));
    endtask

    // Controller sequence: load, incr, then (shift, wait-on-E, incr if E) until R1 is empty.
    task automatic runOperand(input logic [WIDTH-1:0] value, input logic [CNT_W-1:0] expected);
        data_in = value;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_r1 != '0) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (m_e) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        exp_q.push_back(expected);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    initial begin
        rst = 1'b1; data_in = '0; load_regs = 0; incr_r2 = 0; shift = 0; rdy = 1'b1;
        m_r1 = '0; m_r2 = '0; m_e = 1'b0; prev_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("reset_count", 32'(count), 32'd0);
        checkOutput("reset_E", 32'(E), 32'd0);
        checkOutput("reset_zero", 32'(zero), 32'd1);
        checkOutput("reset_result", 32'(result), 32'd0);
        checkOutput("reset_result_valid", 32'(result_valid), 32'd0);
        checkOutput("reset_cmd_err", 32'(cmd_err), 32'd0);
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] operands B5, 00, FF");
        runOperand(8'hB5, 4'd5);
        checkOutput("cmd_err_clean", 32'(cmd_err), 32'd0);
        runOperand(8'h00, 4'd0);
        runOperand(8'hFF, 4'd8);

        $display("[TB] operand 80, E after first shift");
        data_in = 8'h80;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        checkOutput("E_after_shift_80", 32'(E), 32'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        exp_q.push_back(4'd1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        $display("[TB] load and shift together");
        data_in = 8'h0F;
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b1);
        checkOutput("cmd_err_set", 32'(cmd_err), 32'd1);
        checkOutput("count_after_load", 32'(count), 32'hF);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("cmd_err_sticky", 32'(cmd_err), 32'd1);

        $display("[TB] reset mid-count on AA");
        data_in = 8'hAA;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        checkOutput("count_before_reset", 32'(count), 32'd1);
        #2;
        rst = 1'b1;
        rdy = 1'b1;
        #1;
        m_r1 = '0; m_r2 = '0; m_e = 1'b0;
        checkOutput("rst_async_zero", 32'(zero), 32'd1);
        checkOutput("rst_async_count", 32'(count), 32'd0);
        checkOutput("rst_async_E", 32'(E), 32'd0);
        checkOutput("rst_async_cmd_err", 32'(cmd_err), 32'd0);
        checkOutput("rst_async_valid", 32'(result_valid), 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        checkOutput("no_pulse_after_reset", 32'(pulses), 32'd4);
        runOperand(8'h03, 4'd2);

        $display("[TB] back-to-back 01 then 07");
        runOperand(8'h01, 4'd1);
        data_in = 8'h07;
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        checkOutput("result_held", 32'(result), 32'd1);
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        while (m_r1 != '0) begin
            applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
            applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
            if (m_e) applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        end
        checkOutput("result_held_end", 32'(result), 32'd1);
        exp_q.push_back(4'd3);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 1'b1);

        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        checkOutput("pulse_total", 32'(pulses), 32'd7);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: got timeout expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

endmodule
